// File: rtl/core_wakeup_ctrl.sv
// Core wake-up controller: decodes L1.5 interrupt packets into HOLD/RUN/IDLE,
// synchronizes IRQs and core reset, gates requests. Optional HOLD timeout via CORE_WAKEUP_TIMEOUT_EN.
module core_wakeup_ctrl #(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               clk_i,
    input  logic               reset_l,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               rtrn_val_i,
    input  logic               rtrn_int_i,
    input  logic [17:0]        rtrn_data_i,
    input  logic               req_val_i,
    output logic               req_val_o,
    output logic [NUM_IRQ-1:0] irq_o,
    output logic               core_rst_no,
    output logic [1:0]         state_o
);

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] IDLE = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       pkt;
    logic       pkt_por;
    logic       pkt_idle;
    logic       pkt_resume;
    logic       timeout;
    logic       unused_data;

    // Only the type field and the POR thread id matter; the rest of the payload is ignored.
    assign unused_data = ^rtrn_data_i[15:6];

    assign pkt        = rtrn_val_i & rtrn_int_i;
    assign pkt_por    = pkt & (rtrn_data_i[17:16] == 2'b01) & (rtrn_data_i[5:0] == 6'b000001);
    assign pkt_idle   = pkt & (rtrn_data_i[17:16] == 2'b10);
    assign pkt_resume = pkt & (rtrn_data_i[17:16] == 2'b11);

`ifdef CORE_WAKEUP_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] cnt;

    // Counts only while held; saturates on MSB and is cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            cnt <= '0;
        end else if ((state == HOLD) && !cnt[CNT_WIDTH-1]) begin
            cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign timeout = cnt[CNT_WIDTH-1];
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            HOLD:    if (pkt_por || timeout)       state_nxt = RUN;
            RUN:     if (pkt_idle)                 state_nxt = IDLE;
            IDLE:    if (pkt_resume || pkt_por)    state_nxt = RUN;
            default: state_nxt = HOLD;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Core reset release: leaving HOLD is the presync level, so release is synchronous.
    logic [SYNC_STAGES-1:0] rst_sync;

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[SYNC_STAGES-2:0], (state != HOLD)};
        end
    end

    assign core_rst_no = rst_sync[SYNC_STAGES-1];

    logic [NUM_IRQ-1:0] irq_sync [SYNC_STAGES];

    always_ff @(posedge clk_i or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                irq_sync[i] <= '0;
            end
        end else begin
            irq_sync[0] <= irq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                irq_sync[i] <= irq_sync[i-1];
            end
        end
    end

    assign irq_o     = irq_sync[SYNC_STAGES-1];
    assign req_val_o = req_val_i & (state == RUN) & core_rst_no;
    assign state_o   = state;

endmodule
